// File: rtl/score_ram_writer_if.sv
// Game-logic side of score_ram_writer: score request in, status and score_ram write port out.
interface score_ram_writer_if #(
  parameter int unsigned SCORE_W = 16
);
  logic [SCORE_W-1:0] score_in;
  logic               update;
  logic               busy;
  logic               done;
  logic [7:0]         wr_addr;
  logic [7:0]         wr_data;
  logic               wr_en;

  modport master (
    output score_in, update,
    input  busy, done, wr_addr, wr_data, wr_en
  );

  modport slave (
    input  score_in, update,
    output busy, done, wr_addr, wr_data, wr_en
  );
endinterface

// File: rtl/score_ram_writer.sv
// Latches a saturated score, converts it serially to BCD and writes one character per digit to score_ram;
// update->done is SCORE_W+DIGITS+1 cycles. SCORE_LZ_BLANK_EN writes leading zeros as spaces.
module score_ram_writer #(
  parameter int unsigned SCORE_W   = 16,
  parameter int unsigned DIGITS    = 5,
  parameter logic [7:0]  BASE_ADDR = 8'd86
) (
  input logic               Clk,
  input logic               Reset,
  score_ram_writer_if.slave bus
);
  localparam int unsigned BW   = 4 * DIGITS;
  localparam int unsigned SW   = BW + SCORE_W;
  localparam int unsigned CMAX = (SCORE_W > DIGITS) ? SCORE_W : DIGITS;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  function automatic logic [SCORE_W-1:0] sat(input logic [SCORE_W-1:0] s);
    logic [63:0] w;
    w = 64'(s);
    if (w > MAX_VAL) w = MAX_VAL;
    return w[SCORE_W-1:0];
  endfunction

  // One double-dabble step over the combined {bcd, bin} shift register.
  function automatic logic [SW-1:0] dd_step(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    r = v;
    for (int unsigned k = 0; k < DIGITS; k++)
      if (r[SCORE_W+4*k +: 4] >= 4'd5) r[SCORE_W+4*k +: 4] = r[SCORE_W+4*k +: 4] + 4'd3;
    return r << 1;
  endfunction

  typedef enum logic [1:0] {IDLE, CONVERT, WRITE, DONE} state_e;

  state_e             state_q, state_d;
  logic [SW-1:0]      sh_q, sh_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic [SCORE_W-1:0] pval_q, pval_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wr_en_q, wr_en_d;
  logic [7:0]         wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
`ifdef SCORE_LZ_BLANK_EN
  logic               lead_q, lead_d;
`endif

  logic               load;
  logic [SCORE_W-1:0] load_val;
  logic               emit;
  logic [SW-1:0]      src;
  logic [CW-1:0]      idx;
  logic [3:0]         nib;
  logic [7:0]         chr;

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pval_d    = pval_q;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    load      = 1'b0;
    load_val  = sat(bus.score_in);
    emit      = 1'b0;
    src       = sh_q;
    idx       = cnt_q;
    nib       = 4'd0;
    chr       = 8'd0;
`ifdef SCORE_LZ_BLANK_EN
    lead_d    = lead_q;
`endif

    if (bus.update && state_q != IDLE) begin
      pend_d = 1'b1;
      pval_d = sat(bus.score_in);
    end

    case (state_q)
      IDLE: load = bus.update;
      CONVERT: begin
        sh_d  = dd_step(sh_q);
        cnt_d = cnt_q + CW'(1);
        // The last step feeds the first digit write directly so WRITE starts without a gap.
        if (cnt_q == CW'(SCORE_W - 1)) begin
          emit = 1'b1;
          src  = dd_step(sh_q);
          idx  = '0;
        end
      end
      WRITE: begin
        if (cnt_q == CW'(DIGITS)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          emit = 1'b1;
        end
      end
      DONE: begin
        pend_d = 1'b0;
        if (bus.update) begin
          load = 1'b1;
        end else if (pend_q) begin
          load     = 1'b1;
          load_val = pval_q;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      nib = src[SW-1 -: 4];
      chr = 8'h30 + {4'h0, nib};
`ifdef SCORE_LZ_BLANK_EN
      if (lead_q && nib == 4'd0 && idx != CW'(DIGITS - 1)) chr = 8'h20;
      lead_d = lead_q && (nib == 4'd0);
`endif
      sh_d      = src << 4;
      cnt_d     = idx + CW'(1);
      state_d   = WRITE;
      wr_en_d   = 1'b1;
      wr_addr_d = BASE_ADDR + 8'(idx);
      wr_data_d = chr;
    end

    if (load) begin
      sh_d    = {{BW{1'b0}}, load_val};
      cnt_d   = '0;
      state_d = CONVERT;
`ifdef SCORE_LZ_BLANK_EN
      lead_d  = 1'b1;
`endif
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      pval_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'd0;
      wr_data_q <= 8'd0;
`ifdef SCORE_LZ_BLANK_EN
      lead_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pval_q    <= pval_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef SCORE_LZ_BLANK_EN
      lead_q    <= lead_d;
`endif
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
endmodule

// File: tb/tb_score_ram_writer.sv
// Bench for score_ram_writer: two instances (5 digits at 86, 4 digits at 254) against a timeline model.
`timescale 1ns/1ps
module tb_score_ram_writer;
  localparam int SW = 16;

  logic          Clk;
  logic          rst;
  logic          upd;
  logic [SW-1:0] sc;

  score_ram_writer_if #(.SCORE_W(SW)) if5 ();
  score_ram_writer_if #(.SCORE_W(SW)) if4 ();

  assign if5.update   = upd;
  assign if5.score_in = sc;
  assign if4.update   = upd;
  assign if4.score_in = sc;

  score_ram_writer #(.SCORE_W(SW), .DIGITS(5), .BASE_ADDR(8'd86)) dut5 (
    .Clk(Clk), .Reset(rst), .bus(if5));
  score_ram_writer #(.SCORE_W(SW), .DIGITS(4), .BASE_ADDR(8'd254)) dut4 (
    .Clk(Clk), .Reset(rst), .bus(if4));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic cmp(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Behavioural model: a job started at edge E0 writes digit p at t = SW+p, pulses done at SW+DIGITS.
  int          base_a [2] = '{86, 254};
  int          dig_a  [2] = '{5, 4};
  bit          m_act  [2];
  bit          m_pend [2];
  int          m_t    [2];
  longint      m_val  [2];
  longint      m_pval [2];
  logic        m_busy [2];
  logic        m_done [2];
  logic        m_wen  [2];
  logic [7:0]  m_addr [2];
  logic [7:0]  m_data [2];
  bit          mvalid = 1'b0;

  function automatic longint pow10(int n);
    longint r = 1;
    for (int j = 0; j < n; j++) r = r * 10;
    return r;
  endfunction

  function automatic longint satv(logic [SW-1:0] s, longint mx);
    longint v = longint'({48'd0, s});
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [7:0] mchar(longint v, int d, int i);
    longint p = pow10(d - 1 - i);
    logic [7:0] c = 8'h30 + 8'((v / p) % 10);
`ifdef SCORE_LZ_BLANK_EN
    if (i < d - 1 && v < p) c = 8'h20;
`endif
    return c;
  endfunction

  task automatic model_edge(int k);
    int d = dig_a[k];
    longint mx = pow10(d) - 1;
    int p;
    if (rst) begin
      m_act[k] = 0; m_pend[k] = 0; m_busy[k] = 0; m_done[k] = 0;
      m_wen[k] = 0; m_addr[k] = 8'd0; m_data[k] = 8'd0;
      return;
    end
    m_done[k] = 0;
    m_wen[k]  = 0;
    if (!m_act[k]) begin
      if (upd) begin m_act[k] = 1; m_t[k] = 0; m_val[k] = satv(sc, mx); end
    end else begin
      m_t[k]++;
      if (m_t[k] == SW + d + 1) begin
        if (upd) begin m_t[k] = 0; m_val[k] = satv(sc, mx); m_pend[k] = 0; end
        else if (m_pend[k]) begin m_t[k] = 0; m_val[k] = m_pval[k]; m_pend[k] = 0; end
        else m_act[k] = 0;
      end else begin
        if (upd) begin m_pend[k] = 1; m_pval[k] = satv(sc, mx); end
        p = m_t[k] - SW;
        if (p >= 0 && p < d) begin
          m_wen[k]  = 1;
          m_addr[k] = 8'(base_a[k] + p);
          m_data[k] = mchar(m_val[k], d, p);
        end
        if (p == d) m_done[k] = 1;
      end
    end
    m_busy[k] = m_act[k];
  endtask

  always @(posedge Clk) begin
    for (int k = 0; k < 2; k++) model_edge(k);
    mvalid = 1'b1;
  end

  logic [7:0] ram5 [256];
  logic [7:0] ram4 [256];
  logic [7:0] log5 [$];
  logic [7:0] alog5 [$];
  int         dcnt5 = 0;

  initial for (int i = 0; i < 256; i++) begin ram5[i] = 8'h00; ram4[i] = 8'h00; end

  always @(negedge Clk) begin
    if (mvalid) begin
      cmp("busy",    0, 32'(if5.busy),    32'(m_busy[0]));
      cmp("done",    0, 32'(if5.done),    32'(m_done[0]));
      cmp("wr_en",   0, 32'(if5.wr_en),   32'(m_wen[0]));
      cmp("wr_addr", 0, 32'(if5.wr_addr), 32'(m_addr[0]));
      cmp("wr_data", 0, 32'(if5.wr_data), 32'(m_data[0]));
      cmp("busy",    1, 32'(if4.busy),    32'(m_busy[1]));
      cmp("done",    1, 32'(if4.done),    32'(m_done[1]));
      cmp("wr_en",   1, 32'(if4.wr_en),   32'(m_wen[1]));
      cmp("wr_addr", 1, 32'(if4.wr_addr), 32'(m_addr[1]));
      cmp("wr_data", 1, 32'(if4.wr_data), 32'(m_data[1]));
    end
    if (if5.wr_en === 1'b1) begin
      ram5[if5.wr_addr] = if5.wr_data;
      log5.push_back(if5.wr_data);
      alog5.push_back(if5.wr_addr);
    end
    if (if4.wr_en === 1'b1) ram4[if4.wr_addr] = if4.wr_data;
    if (if5.done === 1'b1) dcnt5++;
  end

  task automatic pulse(logic [SW-1:0] v);
    @(negedge Clk); upd = 1'b1; sc = v;
    @(negedge Clk); upd = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((if5.busy || if4.busy) && n < budget) begin @(negedge Clk); n++; end
    cmp("idle_timeout", 0, 32'(if5.busy || if4.busy), 32'd0);
  endtask

  task automatic chk_ram(string name, int k, string exp);
    logic [7:0] a;
    for (int i = 0; i < exp.len(); i++) begin
      a = 8'(base_a[k] + i);
      cmp(name, k, 32'(k == 0 ? ram5[a] : ram4[a]), 32'(exp[i]));
    end
  endtask

  string s1234, s0_5, s0_4, s705, s100, s300, s777;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    string q;
`ifdef SCORE_LZ_BLANK_EN
    s1234 = " 1234"; s0_5 = "    0"; s0_4 = "   0"; s705 = "  705";
    s100 = "  100"; s300 = "  300"; s777 = "  777";
`else
    s1234 = "01234"; s0_5 = "00000"; s0_4 = "0000"; s705 = "00705";
    s100 = "00100"; s300 = "00300"; s777 = "00777";
`endif
    rst = 1'b1; upd = 1'b1; sc = 16'd1234;
    repeat (3) @(negedge Clk);
    cmp("rst_busy",  0, 32'(if5.busy),    32'd0);
    cmp("rst_done",  0, 32'(if5.done),    32'd0);
    cmp("rst_wr_en", 0, 32'(if5.wr_en),   32'd0);
    cmp("rst_addr",  0, 32'(if5.wr_addr), 32'd0);
    cmp("rst_data",  0, 32'(if5.wr_data), 32'd0);
    rst = 1'b0; upd = 1'b0;
    @(negedge Clk);
    cmp("rst_nowrite", 0, 32'(log5.size()), 32'd0);
    cmp("rst_idle",    0, 32'(if5.busy),    32'd0);

    // The negedge right after the sampling edge counts as cycle 1; done shows on cycle 22.
    pulse(16'd1234);
    n = 1;
    while (!if5.done && n < 40) begin @(negedge Clk); n++; end
    cmp("done_latency", 0, 32'(n), 32'd22);
    wait_idle(60);
    chk_ram("s1234", 0, s1234);
    chk_ram("s1234", 1, "1234");
    cmp("wrap_addr", 1, 32'(if4.wr_addr), 32'd1);

    pulse(16'd65535); wait_idle(60);
    chk_ram("s65535", 0, "65535");
    chk_ram("s65535", 1, "9999");
    pulse(16'd12345); wait_idle(60);
    chk_ram("s12345", 0, "12345");
    chk_ram("s12345", 1, "9999");
    pulse(16'd0); wait_idle(60);
    chk_ram("s0", 0, s0_5);
    chk_ram("s0", 1, s0_4);
    pulse(16'd705); wait_idle(60);
    chk_ram("s705", 0, s705);

    log5.delete(); alog5.delete(); d0 = dcnt5;
    @(negedge Clk); upd = 1'b1; sc = 16'd100;
    @(negedge Clk); upd = 1'b0;
    repeat (4) @(negedge Clk);
    upd = 1'b1; sc = 16'd200;
    @(negedge Clk); upd = 1'b0;
    repeat (4) @(negedge Clk);
    upd = 1'b1; sc = 16'd300;
    @(negedge Clk); upd = 1'b0;
    wait_idle(120);
    q = {s100, s300};
    cmp("queue_writes", 0, 32'(log5.size()), 32'd10);
    if (log5.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        cmp("queue_data", 0, 32'(log5[i]),  32'(q[i]));
        cmp("queue_addr", 0, 32'(alog5[i]), 32'(86 + i % 5));
      end
    end
    cmp("queue_dones", 0, 32'(dcnt5 - d0), 32'd2);

    log5.delete(); d0 = dcnt5;
    pulse(16'd4321);
    repeat (7) @(negedge Clk);
    rst = 1'b1;
    @(negedge Clk);
    rst = 1'b0; upd = 1'b1; sc = 16'd777;
    @(negedge Clk);
    upd = 1'b0;
    cmp("midrst_accept",  0, 32'(if5.busy),      32'd1);
    cmp("midrst_nowrite", 0, 32'(log5.size()),   32'd0);
    cmp("midrst_nodone",  0, 32'(dcnt5 - d0),    32'd0);
    wait_idle(60);
    chk_ram("s777", 0, s777);
    cmp("midrst_done", 0, 32'(dcnt5 - d0), 32'd1);

    repeat (1500) begin
      @(negedge Clk);
      rst = ($urandom_range(0, 299) == 0);
      upd = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0: sc = 16'($urandom_range(0, 9));
        1: sc = 16'($urandom_range(0, 999));
        2: sc = 16'($urandom_range(9995, 10005));
        default: sc = 16'($urandom);
      endcase
    end
    @(negedge Clk); rst = 1'b0; upd = 1'b0;
    wait_idle(200);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/score_ram_writer.md
# score_ram_writer

Writes the decimal score text into `score_ram`, the 8-bit character RAM that `color_mapper` scans for the bottom status strip. On an update request the block latches a binary score, converts it to BCD with a serial double-dabble engine, and writes one character code per digit into consecutive RAM locations. It sits between game logic (score accumulator) and the write port of `score_ram`, which `color_mapper` uses read-only.

## Interface

- `SCORE_W`, 16: width of binary score input.
- `DIGITS`, 5: number of decimal digits displayed (1..8).
- `BASE_ADDR`, 8'd86: RAM address of the most significant digit. Text RAM layout is `row*80 + col`; 86 = row 1, col 6.
- `Clk`  in  1  system clock; all logic on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `score_in`  in  SCORE_W  binary score, sampled when `update` is accepted.
- `update`  in  1  request to refresh displayed score; level-sampled each cycle.
- `busy`  out  1  high while a conversion/write sequence is in progress.
- `done`  out  1  one-cycle pulse after the last digit write.
- `wr_addr`  out  8  to `score_ram.write_address`.
- `wr_data`  out  8  to `score_ram.data_In`; character code.
- `wr_en`  out  1  to `score_ram.we`.

## Operation

- FSM states: IDLE, CONVERT, WRITE, DONE.
- IDLE: on `update`=1, latch `min(score_in, 10^DIGITS-1)` into shift register, clear BCD register (4*DIGITS bits), clear shift counter, go to CONVERT.
- CONVERT: one double-dabble step per cycle: every BCD nibble ≥5 gets +3, then `{bcd, bin}` shifts left by 1. Exactly SCORE_W steps, then WRITE.
- WRITE: digit index i = 0..DIGITS-1, most significant first. `wr_addr = BASE_ADDR + i` (8-bit, wraps mod 256), `wr_data = 8'h30 + digit` ('0'..'9'), `wr_en`=1. After i = DIGITS-1, go to DONE.
- DONE: `done`=1 for one cycle. Next state CONVERT if pending set (reloading from pending score, clearing pending), else IDLE.
- `update` while not IDLE: set pending flag and capture (saturated) `score_in` into pending register; later requests overwrite it. At most one re-run queued; only the latest value is displayed.
- `update` in DONE counts as pending (re-run starts immediately, no IDLE cycle).
- Saturation: values ≥ 10^DIGITS display as all nines.
- RAM contents are never cleared by this block; Reset does not touch RAM.

## Timing

- All outputs registered. Reset values: `busy`=0, `done`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0; state IDLE; pending cleared.
- Edge E0 samples `update` in IDLE. `busy`=1 from E0 until the edge leaving DONE to IDLE.
- CONVERT occupies SCORE_W cycles (E0..E(SCORE_W)).
- `wr_en`=1 for exactly DIGITS consecutive cycles; writes commit at edges E(SCORE_W+1)..E(SCORE_W+DIGITS).
- `done` high for one cycle following E(SCORE_W+DIGITS); latency update→done = SCORE_W+DIGITS+1 cycles (22 for defaults).
- `wr_en`=0 outside WRITE; `wr_addr`/`wr_data` hold last values when idle.
- Reset mid-sequence: next edge returns to IDLE with reset values; partially written digits remain in RAM; no `done`.
- Reset and `update` in same cycle: Reset wins; request dropped.

## Configuration

- `SCORE_LZ_BLANK_EN`: when defined, leading zero digits are written as 8'h20 (space); the least significant digit is always a numeral, so score 0 displays right-aligned "0". When undefined, every digit is written as a numeral (zero-padded). Timing identical in both builds.

## Test plan

- Reset: hold Reset 3 cycles → `busy`,`done`,`wr_en`,`wr_addr`,`wr_data` all 0; `update` during Reset produces no writes.
- Defaults, no macro, `score_in`=1234 → writes 0x30,0x31,0x32,0x33,0x34 to addresses 86..90 in order; `done` pulse exactly 22 cycles after update sample.
- `SCORE_LZ_BLANK_EN` defined, `score_in`=0 → 0x20,0x20,0x20,0x20,0x30; `score_in`=705 → 0x20,0x20,0x37,0x30,0x35.
- `DIGITS`=4, `score_in`=12345 → 0x39 ×4 at 86..89 (saturation); `score_in`=65535 with defaults → 0x36,0x35,0x35,0x33,0x35.
- Update 100 at cycle 0, update 200 at cycle 5, update 300 at cycle 10 → first sequence writes "00100", second starts immediately after `done` and writes "00300"; 200 never written; two `done` pulses total.
- Reset asserted at cycle 8 of CONVERT → `wr_en` never asserts, no `done`, block accepts new `update` on first cycle after Reset deasserts.
